// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up init sequence: PRE-all, AREFs, MSET, then tMRD.
// Optional watchdog is compiled in with `define SDRAM_MON_TIMEOUT_EN.
module sdram_init_monitor #(
    parameter int T_POWERUP = 10000,
    parameter int T_RP      = 1,
    parameter int T_RC      = 4,
    parameter int T_MRD     = 2,
    parameter int AREF_MIN  = 2,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cmd,
    input  logic [11:0] sdram_addr,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [2:0]  mode_bl,
    output logic        mode_bt,
    output logic [2:0]  mode_cl,
    output logic [3:0]  aref_cnt
);

    localparam int PU_W  = $clog2(T_POWERUP + 1);
    localparam int MRD_W = (T_MRD > 1) ? $clog2(T_MRD) : 1;
    localparam logic [PU_W-1:0]  PU_MAX     = PU_W'(T_POWERUP);
    localparam logic [MRD_W-1:0] MRD_LAST   = MRD_W'(T_MRD - 1);
    localparam logic [8:0]       RP_GAP     = 9'(T_RP);
    localparam logic [8:0]       RC_GAP     = 9'(T_RC);
    localparam logic [3:0]       AREF_MIN_C = 4'(AREF_MIN);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MSET = 4'b0000;

    localparam logic [2:0] ERR_EARLY   = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_TIMING  = 3'd3;
    localparam logic [2:0] ERR_ADDR    = 3'd4;
    localparam logic [2:0] ERR_MODE    = 3'd5;
    localparam logic [2:0] ERR_SHORT   = 3'd6;

    typedef enum logic [2:0] {S_PWR, S_AREF, S_MRD, S_DONE, S_ERR} state_t;

    state_t           state_reg, state_next;
    logic [PU_W-1:0]  pu_cnt_reg;
    logic [7:0]       gap_cnt_reg;
    logic             last_pre_reg;
    logic [MRD_W-1:0] mrd_cnt_reg;
    logic             init_done_reg, init_err_reg, mode_bt_reg;
    logic [2:0]       err_code_reg, mode_bl_reg, mode_cl_reg;
    logic [3:0]       aref_cnt_reg;

    logic       is_nop, is_pre, is_aref, is_mset, pu_sat, active;
    logic [8:0] gap;
    logic       raise_err, done_set, aref_inc, mode_latch;
    logic [2:0] raise_code;

    // Deselect (cs_n high) is equivalent to NOP
    assign is_nop  = cmd[3] | (cmd == CMD_NOP);
    assign is_pre  = (cmd == CMD_PRE);
    assign is_aref = (cmd == CMD_AREF);
    assign is_mset = (cmd == CMD_MSET);
    assign pu_sat  = (pu_cnt_reg == PU_MAX);
    assign active  = (state_reg == S_PWR) || (state_reg == S_AREF) || (state_reg == S_MRD);
    // Edges elapsed since the previous command, counting this one
    assign gap     = {1'b0, gap_cnt_reg} + 9'd1;

`ifdef SDRAM_MON_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt_reg;
    logic        timeout_hit;
    assign timeout_hit = active && pu_sat && (wd_cnt_reg == TO_LAST);
`endif

    always_comb begin
        state_next = state_reg;
        raise_err  = 1'b0;
        raise_code = 3'd0;
        done_set   = 1'b0;
        aref_inc   = 1'b0;
        mode_latch = 1'b0;
        case (state_reg)
            S_PWR: begin
                if (!is_nop) begin
                    if (is_pre && sdram_addr[10]) begin
                        state_next = S_AREF;
                    end else if (is_pre) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_ADDR;
                    end else begin
                        raise_err  = 1'b1;
                        raise_code = ERR_ORDER;
                    end
                end
            end
            S_AREF: begin
                if (is_aref) begin
                    if (gap < (last_pre_reg ? RP_GAP : RC_GAP)) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_TIMING;
                    end else begin
                        aref_inc = 1'b1;
                    end
                end else if (is_mset) begin
                    if (aref_cnt_reg < AREF_MIN_C) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_SHORT;
                    end else if (gap < RC_GAP) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_TIMING;
                    end else if ((sdram_addr[11:7] != 5'd0) || (sdram_addr[6:5] != 2'b01)) begin
                        raise_err  = 1'b1;
                        raise_code = ERR_MODE;
                    end else begin
                        mode_latch = 1'b1;
                        state_next = S_MRD;
                    end
                end else if (!is_nop) begin
                    raise_err  = 1'b1;
                    raise_code = ERR_ORDER;
                end
            end
            S_MRD: begin
                if (!is_nop) begin
                    raise_err  = 1'b1;
                    raise_code = ERR_TIMING;
                end else if (mrd_cnt_reg == MRD_LAST) begin
                    done_set   = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: ;
        endcase

        // EARLY outranks every other cause detected on the same sample
        if (active && !is_nop && !pu_sat) begin
            raise_err  = 1'b1;
            raise_code = ERR_EARLY;
        end
`ifdef SDRAM_MON_TIMEOUT_EN
        if (timeout_hit && !raise_err && !done_set) begin
            raise_err  = 1'b1;
            raise_code = 3'd7;
        end
`endif
        if (raise_err) begin
            state_next = S_ERR;
            done_set   = 1'b0;
            aref_inc   = 1'b0;
            mode_latch = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_PWR;
            pu_cnt_reg    <= '0;
            gap_cnt_reg   <= '0;
            last_pre_reg  <= 1'b0;
            mrd_cnt_reg   <= '0;
            init_done_reg <= 1'b0;
            init_err_reg  <= 1'b0;
            err_code_reg  <= 3'd0;
            mode_bl_reg   <= 3'd0;
            mode_bt_reg   <= 1'b0;
            mode_cl_reg   <= 3'd0;
            aref_cnt_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (!pu_sat)
                pu_cnt_reg <= pu_cnt_reg + 1'b1;
            if (!is_nop) begin
                gap_cnt_reg  <= '0;
                last_pre_reg <= is_pre;
            end else if (gap_cnt_reg != 8'hFF) begin
                gap_cnt_reg <= gap_cnt_reg + 8'd1;
            end
            if (raise_err) begin
                init_err_reg <= 1'b1;
                err_code_reg <= raise_code;
            end
            if (done_set)
                init_done_reg <= 1'b1;
            if (aref_inc && aref_cnt_reg != 4'hF)
                aref_cnt_reg <= aref_cnt_reg + 4'd1;
            if (mode_latch) begin
                mode_bl_reg <= sdram_addr[2:0];
                mode_bt_reg <= sdram_addr[3];
                mode_cl_reg <= sdram_addr[6:4];
                mrd_cnt_reg <= '0;
            end else if (state_reg == S_MRD) begin
                mrd_cnt_reg <= mrd_cnt_reg + 1'b1;
            end
        end
    end

`ifdef SDRAM_MON_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt_reg <= 16'd0;
        else if (active && pu_sat && wd_cnt_reg != 16'hFFFF)
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
    end
`endif

    assign init_done = init_done_reg;
    assign init_err  = init_err_reg;
    assign err_code  = err_code_reg;
    assign mode_bl   = mode_bl_reg;
    assign mode_bt   = mode_bt_reg;
    assign mode_cl   = mode_cl_reg;
    assign aref_cnt  = aref_cnt_reg;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor: legal init, each error cause, mid-sequence reset.
// Build with +define+SDRAM_MON_TIMEOUT_EN to exercise the watchdog (TIMEOUT = 100).
module tb_sdram_init_monitor;

    localparam int         TB_PU      = 10000;
    localparam int         TB_TIMEOUT = 100;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MSET = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cmd;
    logic [11:0] sdram_addr;
    logic        init_done, init_err, mode_bt;
    logic [2:0]  err_code, mode_bl, mode_cl;
    logic [3:0]  aref_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    sdram_init_monitor #(
        .T_POWERUP(TB_PU),
        .T_RP(1),
        .T_RC(4),
        .T_MRD(2),
        .AREF_MIN(2),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .sdram_addr(sdram_addr),
        .init_done(init_done),
        .init_err(init_err),
        .err_code(err_code),
        .mode_bl(mode_bl),
        .mode_bt(mode_bt),
        .mode_cl(mode_cl),
        .aref_cnt(aref_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sampled edge: drive at the falling edge, observe at the next falling edge
    task automatic tick(input logic [3:0] c, input logic [11:0] a);
        cmd        = c;
        sdram_addr = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) tick(NOP, 12'h000);
    endtask

    task automatic do_reset();
        cmd        = NOP;
        sdram_addr = 12'h000;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cmd        = NOP;
        sdram_addr = 12'h000;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({init_done, init_err, err_code, mode_bl, mode_bt, mode_cl, aref_cnt} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {init_done, init_err, err_code, mode_bl, mode_bt, mode_cl, aref_cnt});
        end
        rst_n = 1'b1;
        $display("[TB] test_reset done");
    endtask

    // Full legal init; PRE at edge TB_PU+1, AREF +1, AREF +5, MSET(0x032) +9
    task automatic test_legal(input string tag);
        nops(TB_PU);
        tick(PRE, 12'h400);
        tick(AREF, 12'h000);
        nops(3);
        tick(AREF, 12'h000);
        tests_run++;
        if (aref_cnt !== 4'd2) begin
            tests_failed++;
            $display("FAIL %s_aref_cnt: got %0d required 2", tag, aref_cnt);
        end
        nops(3);
        tick(MSET, 12'h032);
        tick(NOP, 12'h000);
        tests_run++;
        if (init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done_early: got %0b required 0 one cycle after MSET", tag, init_done);
        end
        tick(NOP, 12'h000);
        tests_run++;
        if (init_done !== 1'b1 || init_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: got done=%0b err=%0b required done=1 err=0", tag, init_done, init_err);
        end
        tests_run++;
        if (mode_bl !== 3'd2 || mode_bt !== 1'b0 || mode_cl !== 3'd3 || aref_cnt !== 4'd2) begin
            tests_failed++;
            $display("FAIL %s_mode: got bl=%0d bt=%0b cl=%0d aref=%0d required bl=2 bt=0 cl=3 aref=2",
                     tag, mode_bl, mode_bt, mode_cl, aref_cnt);
        end
        // After done, ownership has passed on: nothing may be flagged or counted
        tick(PRE, 12'h000);
        tick(AREF, 12'h000);
        tick(NOP, 12'h000);
        tests_run++;
        if (init_err !== 1'b0 || init_done !== 1'b1 || aref_cnt !== 4'd2) begin
            tests_failed++;
            $display("FAIL %s_done_frozen: got done=%0b err=%0b aref=%0d required 1 0 2",
                     tag, init_done, init_err, aref_cnt);
        end
        $display("[TB] test_legal (%s) done", tag);
    endtask

    task automatic test_early();
        do_reset();
        nops(TB_PU - 1);
        tests_run++;
        if (init_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_pre_quiet: got err=%0b required 0", init_err);
        end
        tick(PRE, 12'h400);
        tick(NOP, 12'h000);
        tests_run++;
        if (init_err !== 1'b1 || err_code !== 3'd1 || init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL early: got err=%0b code=%0d done=%0b required 1 1 0", init_err, err_code, init_done);
        end
        $display("[TB] test_early done");
    endtask

    task automatic test_timing();
        do_reset();
        nops(TB_PU);
        tick(PRE, 12'h400);
        tick(AREF, 12'h000);
        nops(2);
        tick(AREF, 12'h000);
        tick(NOP, 12'h000);
        tests_run++;
        if (init_err !== 1'b1 || err_code !== 3'd3 || aref_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL timing_gap3: got err=%0b code=%0d aref=%0d required 1 3 1", init_err, err_code, aref_cnt);
        end
        $display("[TB] test_timing done");
    endtask

    task automatic test_aref_short();
        do_reset();
        nops(TB_PU);
        tick(PRE, 12'h400);
        tick(AREF, 12'h000);
        nops(3);
        tick(MSET, 12'h032);
        tick(NOP, 12'h000);
        tests_run++;
        if (init_err !== 1'b1 || err_code !== 3'd6 || mode_cl !== 3'd0) begin
            tests_failed++;
            $display("FAIL aref_short: got err=%0b code=%0d cl=%0d required 1 6 0", init_err, err_code, mode_cl);
        end
        $display("[TB] test_aref_short done");
    endtask

    task automatic test_pre_addr();
        do_reset();
        nops(TB_PU);
`ifndef SDRAM_MON_TIMEOUT_EN
        nops(150);
        tests_run++;
        if (init_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_watchdog: got err=%0b code=%0d required err=0", init_err, err_code);
        end
`endif
        tick(PRE, 12'h000);
        tick(NOP, 12'h000);
        tests_run++;
        if (init_err !== 1'b1 || err_code !== 3'd4) begin
            tests_failed++;
            $display("FAIL pre_addr: got err=%0b code=%0d required 1 4", init_err, err_code);
        end
        $display("[TB] test_pre_addr done");
    endtask

    task automatic test_mode();
        do_reset();
        nops(TB_PU);
        tick(PRE, 12'h400);
        tick(AREF, 12'h000);
        nops(3);
        tick(AREF, 12'h000);
        nops(3);
        tick(MSET, 12'h012);
        nops(3);
        tests_run++;
        if (init_err !== 1'b1 || err_code !== 3'd5 || init_done !== 1'b0 || mode_cl !== 3'd0) begin
            tests_failed++;
            $display("FAIL mode_cl1: got err=%0b code=%0d done=%0b cl=%0d required 1 5 0 0",
                     init_err, err_code, init_done, mode_cl);
        end
        $display("[TB] test_mode done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        nops(TB_PU);
        tick(PRE, 12'h400);
        tick(AREF, 12'h000);
        tick(NOP, 12'h000);
        tests_run++;
        if (aref_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got aref=%0d required 1", aref_cnt);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({init_done, init_err, err_code, mode_bl, mode_bt, mode_cl, aref_cnt} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear: got %0h required 0",
                     {init_done, init_err, err_code, mode_bl, mode_bt, mode_cl, aref_cnt});
        end
        do_reset();
        test_legal("replay");
    endtask

`ifdef SDRAM_MON_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        nops(TB_PU + TB_TIMEOUT - 1);
        tests_run++;
        if (init_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: got err=%0b code=%0d required 0", init_err, err_code);
        end
        tick(NOP, 12'h000);
        tests_run++;
        if (init_err !== 1'b1 || err_code !== 3'd7 || init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout: got err=%0b code=%0d done=%0b required 1 7 0", init_err, err_code, init_done);
        end
        $display("[TB] test_timeout done");
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        cmd        = NOP;
        sdram_addr = 12'h000;
        test_reset();
        test_legal("legal");
        test_early();
        test_timing();
        test_aref_short();
        test_pre_addr();
        test_mode();
        test_reset_mid();
`ifdef SDRAM_MON_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
